ret_stack_pred: RTL

- Front-end return-address predictor. Sits directly upstream of the call/return queue, in the fetch stage.
- Takes pre-decoded fetch packets and maintains a speculative circular return stack.
- Emits a registered predicted target per packet to the downstream stage.
- Checkpoints stack state per call/ret so a backend redirect can restore it in one cycle.

---
 rtl/ret_stack_pred_pkg.sv | 20 ++
 rtl/ret_stack_ckpt_fifo.sv | 72 +++++++
 rtl/ret_stack_pred.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ret_stack_pred_pkg.sv
// Shared defaults, instruction size and checkpoint record layout for the return-stack predictor.
package ret_stack_pred_pkg;

    localparam int unsigned ADDRWIDE_DEF = 32;
    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned PTRWIDE_DEF  = 3;
    localparam int unsigned CKPTNUM_DEF  = 4;
    localparam int unsigned CKPTWIDE_DEF = 2;

    // Bytes per instruction; the fall-through / link address is PC + INSN_BYTES.
    localparam int unsigned INSN_BYTES = 4;

    // Stack state captured before a call/ret updates it.
    typedef struct packed {
        logic [PTRWIDE_DEF-1:0]  top;
        logic [PTRWIDE_DEF:0]    count;
        logic [ADDRWIDE_DEF-1:0] entry;
    } ckpt_t;

endpackage

// File: rtl/ret_stack_ckpt_fifo.sv
// Checkpoint ring for the return-stack predictor: allocate at tail, retire at head,
// truncate back to a named checkpoint on redirect and hand its record back.
module ret_stack_ckpt_fifo
    import ret_stack_pred_pkg::*;
#(
    parameter int unsigned CKPTNUM  = CKPTNUM_DEF,
    parameter int unsigned CKPTWIDE = CKPTWIDE_DEF
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                Alloc,
    input  ckpt_t               AllocData,
    input  logic                Commit,
    input  logic                Redirect,
    input  logic [CKPTWIDE-1:0] RedirectCkptId,
    output logic [CKPTWIDE-1:0] AllocId,
    output ckpt_t               RestoreData,
    output logic                CkptFull
);

    logic [CKPTWIDE-1:0] head, head_n, tail, tail_n, span;
    logic [CKPTWIDE:0]   live, live_n;
    logic                commit_eff;
    ckpt_t               ring [CKPTNUM];

    assign commit_eff  = Commit && (live != '0);
    assign AllocId     = tail;
    assign RestoreData = ring[RedirectCkptId];
    assign CkptFull    = (live == (CKPTWIDE+1)'(CKPTNUM));

    // Next head/tail/live count from alloc, commit and redirect.
    always_comb begin
        head_n = head;
        tail_n = tail;
        live_n = live;
        span   = '0;
        if (Redirect) begin
            tail_n = RedirectCkptId;
            if (commit_eff && (RedirectCkptId == head)) begin
                // Restored checkpoint is also retired: ring empties; head stays equal to tail.
                live_n = '0;
            end else begin
                head_n = head + CKPTWIDE'(commit_eff);
                span   = RedirectCkptId - head_n;
                live_n = {1'b0, span};
            end
        end else begin
            if (Alloc)      tail_n = tail + CKPTWIDE'(1);
            if (commit_eff) head_n = head + CKPTWIDE'(1);
            live_n = live + {{CKPTWIDE{1'b0}}, Alloc} - {{CKPTWIDE{1'b0}}, commit_eff};
        end
    end

    // Ring pointer registers.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            head <= '0;
            tail <= '0;
            live <= '0;
        end else begin
            head <= head_n;
            tail <= tail_n;
            live <= live_n;
        end
    end

    // Checkpoint record storage; only live slots are ever read back.
    always_ff @(posedge Clk) begin
        if (Alloc) ring[tail] <= AllocData;
    end

endmodule

// File: rtl/ret_stack_pred.sv
// Speculative circular return-address stack with per-call/ret checkpoints and a
// registered prediction output. Optional perf counters under RET_STACK_PERF_EN.
module ret_stack_pred
    import ret_stack_pred_pkg::*;
#(
    parameter int unsigned ADDRWIDE = ADDRWIDE_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned PTRWIDE  = PTRWIDE_DEF,
    parameter int unsigned CKPTNUM  = CKPTNUM_DEF,
    parameter int unsigned CKPTWIDE = CKPTWIDE_DEF
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                FetchValid,
    input  logic [ADDRWIDE-1:0] FetchPc,
    input  logic                FetchIsCall,
    input  logic                FetchIsRet,
    output logic                FetchReady,
    output logic                PredValid,
    output logic [ADDRWIDE-1:0] PredTarget,
    output logic                PredHit,
    output logic [CKPTWIDE-1:0] PredCkptId,
    input  logic                PredReady,
    input  logic                Redirect,
    input  logic [CKPTWIDE-1:0] RedirectCkptId,
    input  logic                Commit,
    output logic                StackEmpty,
    output logic                CkptFull
`ifdef RET_STACK_PERF_EN
    ,
    output logic [31:0]         PerfRetHit,
    output logic [31:0]         PerfRetMiss,
    output logic [31:0]         PerfOverflow
`endif
);

    localparam logic [PTRWIDE:0] FULL_COUNT = (PTRWIDE+1)'(DEPTH);

    logic [ADDRWIDE-1:0] stack [DEPTH];
    logic [PTRWIDE-1:0]  top, top_n, wr_idx;
    logic [PTRWIDE:0]    count, count_n;
    logic [ADDRWIDE-1:0] link, top_entry, tgt, wr_data;
    logic                wr_en, hit, accept, alloc, ckpt_full;
    logic [CKPTWIDE-1:0] alloc_id;
    ckpt_t               save, restore;

    assign FetchReady = !ckpt_full && !Redirect && (!PredValid || PredReady);
    assign accept     = FetchValid && FetchReady;
    assign alloc      = accept && (FetchIsCall || FetchIsRet);
    assign link       = FetchPc + ADDRWIDE'(INSN_BYTES);
    assign top_entry  = stack[top];
    assign save       = '{top: top, count: count, entry: top_entry};
    assign StackEmpty = (count == '0);
    assign CkptFull   = ckpt_full;

    ret_stack_ckpt_fifo #(
        .CKPTNUM  (CKPTNUM),
        .CKPTWIDE (CKPTWIDE)
    ) u_ckpt (
        .Clk            (Clk),
        .Rest           (Rest),
        .Alloc          (alloc),
        .AllocData      (save),
        .Commit         (Commit),
        .Redirect       (Redirect),
        .RedirectCkptId (RedirectCkptId),
        .AllocId        (alloc_id),
        .RestoreData    (restore),
        .CkptFull       (ckpt_full)
    );

    // Stack pointer/count update, single stack write and prediction for the accepted packet.
    always_comb begin
        top_n   = top;
        count_n = count;
        wr_en   = 1'b0;
        wr_idx  = top;
        wr_data = link;
        tgt     = link;
        hit     = 1'b0;
        if (Redirect) begin
            top_n   = restore.top;
            count_n = restore.count;
            wr_en   = 1'b1;
            wr_idx  = restore.top;
            wr_data = restore.entry;
        end else if (accept) begin
            if (FetchIsCall && FetchIsRet) begin
                // Pop then push collapses to a replace of the top entry.
                tgt   = top_entry;
                hit   = (count != '0);
                wr_en = 1'b1;
                if (count == '0) count_n = (PTRWIDE+1)'(1);
            end else if (FetchIsCall) begin
                top_n  = top + PTRWIDE'(1);
                wr_en  = 1'b1;
                wr_idx = top_n;
                if (count != FULL_COUNT) count_n = count + (PTRWIDE+1)'(1);
            end else if (FetchIsRet && (count != '0)) begin
                tgt     = top_entry;
                hit     = 1'b1;
                top_n   = top - PTRWIDE'(1);
                count_n = count - (PTRWIDE+1)'(1);
            end
        end
    end

    // Stack storage, cleared on reset.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else if (wr_en) begin
            stack[wr_idx] <= wr_data;
        end
    end

    // Top pointer and occupancy count.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            top   <= '0;
            count <= '0;
        end else begin
            top   <= top_n;
            count <= count_n;
        end
    end

    // Registered prediction: load on accept, hold while stalled, drop on consume or redirect.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            PredValid  <= 1'b0;
            PredTarget <= '0;
            PredHit    <= 1'b0;
            PredCkptId <= '0;
        end else if (Redirect) begin
            PredValid <= 1'b0;
        end else if (accept) begin
            PredValid  <= 1'b1;
            PredTarget <= tgt;
            PredHit    <= hit;
            PredCkptId <= alloc_id;
        end else if (PredReady) begin
            PredValid <= 1'b0;
        end
    end

`ifdef RET_STACK_PERF_EN
    // Wrapping perf counters; redirects do not roll them back.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            PerfRetHit   <= '0;
            PerfRetMiss  <= '0;
            PerfOverflow <= '0;
        end else if (accept) begin
            if (FetchIsRet && (count != '0)) PerfRetHit <= PerfRetHit + 32'd1;
            if (FetchIsRet && (count == '0)) PerfRetMiss <= PerfRetMiss + 32'd1;
            if (FetchIsCall && !FetchIsRet && (count == FULL_COUNT))
                PerfOverflow <= PerfOverflow + 32'd1;
        end
    end
`endif

endmodule
